// File: rtl/base_sys_st2mem_pkg.sv
// Shared widths, FSM encoding and byte-lane helpers for the stream-to-memory writer.
// Holds no logic of its own; no latency, no backpressure.
package base_sys_st2mem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    E_IDLE  = 3'd0,
    E_ARMED = 3'd1,
    E_WRITE = 3'd2,
    E_DRAIN = 3'd3,
    E_DONE  = 3'd4
  } st_e;

  localparam logic [2:0] ST_IDLE  = E_IDLE;
  localparam logic [2:0] ST_ARMED = E_ARMED;
  localparam logic [2:0] ST_WRITE = E_WRITE;
  localparam logic [2:0] ST_DRAIN = E_DRAIN;
  localparam logic [2:0] ST_DONE  = E_DONE;

  // Indexed by snk_empty: each unused byte strips one lane from the top.
  localparam logic [3:0][BE_W-1:0] EMPTY_BE = {4'b0001, 4'b0011, 4'b0111, 4'b1111};

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/base_sys_st2mem_wr_pipe.sv
// Registered memory write stage: one strobe per request, issued one cycle after wr_en.
// Latency 1 cycle; never stalls (memory port assumed always writable).
module base_sys_st2mem_wr_pipe
  import base_sys_st2mem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata
);

  logic              vld_q,  vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BE_W-1:0]   be_q,   be_d;

  always_comb begin
    vld_d  = wr_en;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    if (wr_en) begin
      addr_d = wr_addr;
      data_d = wr_data;
      be_d   = wr_be;
    end
  end

  // Async clear drops any strobe already staged for the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
      be_q   <= be_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = vld_q;
  assign mem_write      = vld_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = data_q;

endmodule

// File: rtl/base_sys_st2mem_writer.sv
// Captures one Avalon-ST frame into a memory region; optional checksum via ST2MEM_CHECKSUM_EN.
// Write lands 1 cycle after beat acceptance; sink ready only while ARMED/WRITE/DRAIN.
module base_sys_st2mem_writer
  import base_sys_st2mem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_words,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [1:0]        snk_empty,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] frame_words,
  output logic              err_cfg,
  output logic              err_ovf,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [31:0] DEPTH_U = DEPTH;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] frame_words_q, frame_words_d;
  logic              err_cfg_q, err_cfg_d;
  logic              err_ovf_q, err_ovf_d;

  logic              accept;
  logic              cfg_ok;
  logic              start_ok;
  logic [ADDR_W:0]   cfg_end;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BE_W-1:0]   wr_be;

  // One extra bit so base+words cannot wrap before the depth compare.
  assign cfg_end  = {1'b0, cfg_base} + {1'b0, cfg_words};
  assign cfg_ok   = (cfg_words != '0) && (32'(cfg_end) <= DEPTH_U);
  assign start_ok = (state_q == ST_IDLE) && start && cfg_ok;

  assign snk_ready = (state_q == ST_ARMED) || (state_q == ST_WRITE) || (state_q == ST_DRAIN);
  assign accept    = snk_valid && snk_ready;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    words_d       = words_q;
    offset_d      = offset_q;
    frame_words_d = frame_words_q;
    err_cfg_d     = err_cfg_q;
    err_ovf_d     = err_ovf_q;
    wr_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          base_d    = cfg_base;
          words_d   = cfg_words;
          offset_d  = '0;
          err_cfg_d = 1'b0;
          err_ovf_d = 1'b0;
          state_d   = ST_ARMED;
        end else if (start) begin
          err_cfg_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (accept && snk_sop) begin
          wr_en    = 1'b1;
          offset_d = offset_q + ADDR_W'(1);
          state_d  = snk_eop ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          // Region full: this beat would exceed cfg_words, so drop the rest of the frame.
          if (offset_q == words_q) begin
            err_ovf_d = 1'b1;
            state_d   = snk_eop ? ST_DONE : ST_DRAIN;
          end else begin
            wr_en    = 1'b1;
            offset_d = offset_q + ADDR_W'(1);
            if (snk_eop) state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && snk_eop) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) frame_words_d = offset_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      words_q       <= '0;
      offset_q      <= '0;
      frame_words_q <= '0;
      err_cfg_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      words_q       <= words_d;
      offset_q      <= offset_d;
      frame_words_q <= frame_words_d;
      err_cfg_q     <= err_cfg_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign wr_addr = base_q + offset_q;
  assign wr_be   = snk_eop ? EMPTY_BE[snk_empty] : {BE_W{1'b1}};

  base_sys_st2mem_wr_pipe #(
    .ADDR_W(ADDR_W)
  ) u_wr_pipe (
    .clk            (clk),
    .rst_n          (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (snk_data),
    .wr_be          (wr_be),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata)
  );

`ifdef ST2MEM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Summed at acceptance so the final word is already included when done pulses.
  always_comb begin
    checksum_d = checksum_q;
    if (start_ok) checksum_d = '0;
    else if (wr_en) checksum_d = checksum_q + (snk_data & be_to_mask(wr_be));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign frame_words = frame_words_q;
  assign err_cfg     = err_cfg_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: doc/base_sys_st2mem_writer.md
BASE_SYS_ST2MEM_WRITER -- requirements
Module: base_sys_st2mem_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-002 SHALL have parameter DEPTH, default 10000, memory depth in 32-bit words.
REQ-003 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  in  1  sole clock
  reset_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse, arms a frame capture
  cfg_base  in  ADDR_W  first word address of target region
  cfg_words  in  ADDR_W  region length in words
  snk_data  in  32  Avalon-ST sink data
  snk_valid  in  1  sink beat valid
  snk_ready  out  1  sink ready (readyLatency 0)
  snk_sop / snk_eop  in  1 each  start / end of packet
  snk_empty  in  2  unused byte lanes on eop beat
  mem_address  out  ADDR_W  memory write address (feeds sys_mem port s2)
  mem_chipselect / mem_write  out  1 each  memory write strobe
  mem_byteenable  out  4  byte lanes
  mem_writedata  out  32  write data
  busy  out  1  high outside IDLE
  done  out  1  one-cycle pulse at frame end
  frame_words  out  ADDR_W  words written in last frame
  err_cfg / err_ovf  out  1 each  sticky error flags
  checksum  out  32  frame checksum (see Configuration)

Function
REQ-004 States IDLE, ARMED, WRITE, DRAIN, DONE.
REQ-005 IDLE: start with cfg_words!=0 and cfg_base+cfg_words<=DEPTH -> latch cfg, ARMED; otherwise set err_cfg, stay IDLE.
REQ-006 start outside IDLE SHALL be ignored.
REQ-007 snk_ready SHALL be 1 in ARMED, WRITE, DRAIN; 0 in IDLE, DONE.
REQ-008 ARMED: accepted beats without sop discarded; accepted sop beat written, -> WRITE (or DONE if eop on same beat).
REQ-009 Each accepted beat in ARMED(sop)/WRITE SHALL produce exactly one write, 1 cycle after acceptance (registered stage): mem_chipselect=mem_write=1 for one cycle.
REQ-010 mem_address = latched cfg_base + offset; offset starts 0 per frame, +1 per written word, ADDR_W-bit unsigned, no wrap.
REQ-011 mem_byteenable = 4'b1111 except eop beat: empty=k clears the k most-significant lanes (1->0111, 2->0011, 3->0001).
REQ-012 eop beat written -> DONE; DONE lasts one cycle: done=1, frame_words=offset count, -> IDLE.
REQ-013 Beat that would make offset equal cfg_words+1 SHALL not be written: set err_ovf, -> DRAIN (or DONE if that beat carries eop); DRAIN discards until eop, then DONE.
REQ-014 sop seen in WRITE SHALL be treated as ordinary data.
REQ-015 Back-to-back valid beats SHALL be accepted every cycle (one write per cycle, no bubbles).
REQ-016 err_cfg/err_ovf cleared only by accepted start or reset.

Reset
REQ-017 reset_n low SHALL immediately force IDLE, all outputs 0, pending registered write discarded; frame_words, checksum, errors 0.
REQ-018 Reset mid-frame SHALL leave no partial write strobe after reset_n assertion.

Configuration
REQ-019 Macro ST2MEM_CHECKSUM_EN defined: checksum = mod-2^32 sum of written mem_writedata (byteenable-masked), cleared on accepted start, final at done.
REQ-020 Without ST2MEM_CHECKSUM_EN: checksum port present, tied 0, no adder logic.

Structure
REQ-021 Package base_sys_st2mem_pkg SHALL hold DATA_W=32, BE_W=4, state enum, empty-to-byteenable constant table.
REQ-022 Sub-module base_sys_st2mem_wr_pipe SHALL implement the registered write stage (address, data, byteenable, strobe).

Verification
REQ-023 base=0x0100, words=4, 3-beat frame (sop..eop, empty=0) -> writes 0x0100..0x0102, done, frame_words=3.
REQ-024 1-beat frame sop+eop, empty=2 -> single write byteenable 0011, done next cycle.
REQ-025 words=2, 5-beat frame -> 2 writes, err_ovf=1, remaining beats drained, done, frame_words=2.
REQ-026 base=9998, words=4 -> err_cfg=1, busy stays 0, no writes.
REQ-027 Non-sop beats in ARMED then sop frame -> only sop-onward beats written; with macro, data 1,2,3 -> checksum=6.
REQ-028 reset_n low during WRITE with beat just accepted -> no mem_write after reset, busy=0, outputs 0.
